sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: ACC_W, default 8, accumulator width in bits (legal 6..16).
REQ-002 Parameter: N_SAMPLES, default 4, number of adder results accumulated per frame (legal 1..15).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: clear  input  1  synchronous abort; returns block to IDLE.
REQ-006 Port: in_valid  input  1  upstream adder result present.
REQ-007 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port: in_sum  input  4  4-bit sum from upstream ripple-carry adder.
REQ-009 Port: in_cout  input  1  carry-out from upstream adder.
REQ-010 Port: acc_out  output  ACC_W  running/final accumulated total.
REQ-011 Port: acc_valid  output  1  frame total complete and held.
REQ-012 Port: out_ready  input  1  downstream consumes the frame total.
REQ-013 Port: sample_cnt  output  4  beats accepted in current frame.
REQ-014 Port: overflow  output  1  sticky per-frame flag: accumulation exceeded 2^ACC_W-1.

Function
REQ-015 Beat value SHALL be {in_cout, in_sum}, 5 bits, zero-extended to ACC_W+1 before addition.
REQ-016 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other condition.
REQ-017 in_ready SHALL equal (state != DONE) AND (clear = 0), combinationally.
REQ-018 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-019 IDLE: acc_out=0, sample_cnt=0, overflow=0; an accepted beat loads acc_out with the beat value and moves to ACCUM (or DONE if N_SAMPLES=1).
REQ-020 ACCUM: each accepted beat adds to acc_out and increments sample_cnt; no beat -> hold all registers.
REQ-021 When the accepted beat makes sample_cnt equal N_SAMPLES, next state SHALL be DONE.
REQ-022 acc_out and sample_cnt SHALL reflect an accepted beat exactly one cycle after acceptance (1-cycle latency).
REQ-023 DONE: acc_valid=1, acc_out and overflow held stable, in_ready=0.
REQ-024 DONE with out_ready=1: next state IDLE with acc_out, sample_cnt, overflow cleared on that edge; acc_valid SHALL be 1 for at least one cycle.
REQ-025 acc_valid SHALL be 0 in IDLE and ACCUM.
REQ-026 Addition carry beyond ACC_W bits SHALL set overflow; overflow stays set until frame ends (IDLE) or clear/reset.
REQ-027 Default (wrap) mode: acc_out SHALL take the low ACC_W bits of the sum.
REQ-028 clear=1 SHALL take priority over acceptance and out_ready: next state IDLE, all outputs at reset values; a coincident in_valid beat is dropped (in_ready already 0).

Reset
REQ-029 reset=1 SHALL immediately (without clock) force state IDLE, acc_out=0, sample_cnt=0, overflow=0, acc_valid=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; first beat after deassertion starts a new frame.
REQ-031 in_ready SHALL be 0 while reset=1.

Configuration
REQ-032 Macro SUM_ACC_SAT_EN: when defined, an overflowing addition SHALL clamp acc_out to 2^ACC_W-1 and hold it there for the rest of the frame; overflow still sets.
REQ-033 Without SUM_ACC_SAT_EN, wrap behaviour of REQ-027 SHALL apply; all other behaviour identical.

Verification
REQ-034 Defaults; beats {cout,sum}=5,10,31,16 back-to-back, out_ready=0 -> acc_out=62, acc_valid=1, sample_cnt=4, overflow=0, in_ready=0 held.
REQ-035 From REQ-034 state, out_ready=1 one cycle -> next cycle IDLE, acc_out=0, acc_valid=0, in_ready=1.
REQ-036 N_SAMPLES=10, ten beats of 31, no macro -> acc_out=54, overflow=1; with SUM_ACC_SAT_EN -> acc_out=255, overflow=1.
REQ-037 Defaults; beats 7,7 with in_valid gaps of 3 idle cycles -> acc_out=7 then 14, held during gaps, sample_cnt=2, acc_valid=0.
REQ-038 Two beats accepted (acc_out=12), then reset pulse mid-cycle -> outputs 0 asynchronously; next beat 3 -> acc_out=3, sample_cnt=1.
REQ-039 clear=1 together with in_valid=1, in_sum=9 in ACCUM -> beat dropped, next cycle IDLE, acc_out=0, sample_cnt=0.

Source files
------------

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: adder-result input handshake and frame-total output bundle
interface sum_accumulator_if #(parameter int ACC_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_cout;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             out_ready;
  logic [3:0]       sample_cnt;
  logic             overflow;
  modport master (output in_valid, in_sum, in_cout, out_ready,
                  input  in_ready, acc_out, acc_valid, sample_cnt, overflow);
  modport slave  (input  in_valid, in_sum, in_cout, out_ready,
                  output in_ready, acc_out, acc_valid, sample_cnt, overflow);
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates N_SAMPLES 5-bit adder results per frame; SUM_ACC_SAT_EN selects saturating instead of wrapping totals
module sum_accumulator #(
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  sum_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, added;
  logic [3:0]       cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [ACC_W:0]   total;
  logic             accept, last, flush;
  // acc is zero in IDLE, so the first beat of a frame loads through the same adder
  assign total  = {1'b0, acc} + (ACC_W+1)'({bus.in_cout, bus.in_sum});
`ifdef SUM_ACC_SAT_EN
  assign added  = total[ACC_W] ? '1 : total[ACC_W-1:0];
`else
  assign added  = total[ACC_W-1:0];
`endif
  assign bus.in_ready   = state != DONE && !clear && !reset;
  assign accept         = bus.in_valid && bus.in_ready;
  assign last           = cnt + 4'd1 == 4'(N_SAMPLES);
  assign flush          = clear || (state == DONE && bus.out_ready);
  assign bus.acc_out    = acc;
  assign bus.sample_cnt = cnt;
  assign bus.overflow   = ovf;
  assign bus.acc_valid  = state == DONE;
  always_comb begin
    state_n = flush ? IDLE : accept ? (last ? DONE : ACCUM) : state;
    acc_n   = flush ? '0 : accept ? added : acc;
    cnt_n   = flush ? '0 : accept ? cnt + 4'd1 : cnt;
    ovf_n   = flush ? 1'b0 : ovf | (accept & total[ACC_W]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: table-driven frame checks plus reset, clear and overflow sequences
module tb_sum_accumulator;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
  int tests = 0, fails = 0;
  sum_accumulator_if #(.ACC_W(8)) a ();
  sum_accumulator_if #(.ACC_W(8)) b ();
  sum_accumulator #(.ACC_W(8), .N_SAMPLES(4))  dut_a (.clk(clk), .reset(reset), .clear(clear), .bus(a));
  sum_accumulator #(.ACC_W(8), .N_SAMPLES(10)) dut_b (.clk(clk), .reset(reset), .clear(1'b0), .bus(b));
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] beat; logic ordy; logic clr;
    int acc; int cnt; logic av; logic ovf; logic rdy;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(logic v, logic [4:0] beat, logic ordy, logic clr,
                              int acc, int cnt, logic av, logic ovf, logic rdy);
    vec_t r;
    r.v = v; r.beat = beat; r.ordy = ordy; r.clr = clr;
    r.acc = acc; r.cnt = cnt; r.av = av; r.ovf = ovf; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive_a(logic v, logic [4:0] beat, logic ordy, logic clr);
    a.in_valid = v; a.in_cout = beat[4]; a.in_sum = beat[3:0]; a.out_ready = ordy; clear = clr;
  endtask

  task automatic check_a(string n, int acc, int cnt, logic av, logic ovf, logic rdy);
    chk({n, ".acc"}, 32'(a.acc_out), acc);
    chk({n, ".cnt"}, 32'(a.sample_cnt), cnt);
    chk({n, ".valid"}, 32'(a.acc_valid), 32'(av));
    chk({n, ".ovf"}, 32'(a.overflow), 32'(ovf));
    chk({n, ".ready"}, 32'(a.in_ready), 32'(rdy));
  endtask

  task automatic step_a(logic v, logic [4:0] beat, logic ordy, logic clr);
    @(negedge clk);
    drive_a(v, beat, ordy, clr);
    @(posedge clk);
    #1 drive_a(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    int exp9, exp10;
    drive_a(1'b0, 5'd0, 1'b0, 1'b0);
    b.in_valid = 1'b0; b.in_cout = 1'b1; b.in_sum = 4'hF; b.out_ready = 1'b0;
    tbl[0]  = mk(1, 5'd5,  0, 0,  5, 1, 0, 0, 1);
    tbl[1]  = mk(1, 5'd10, 0, 0, 15, 2, 0, 0, 1);
    tbl[2]  = mk(1, 5'd31, 0, 0, 46, 3, 0, 0, 1);
    tbl[3]  = mk(1, 5'd16, 0, 0, 62, 4, 1, 0, 0);
    tbl[4]  = mk(0, 5'd0,  0, 0, 62, 4, 1, 0, 0);
    tbl[5]  = mk(1, 5'd9,  0, 0, 62, 4, 1, 0, 0);
    tbl[6]  = mk(0, 5'd0,  1, 0,  0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 5'd7,  0, 0,  7, 1, 0, 0, 1);
    tbl[8]  = mk(0, 5'd0,  0, 0,  7, 1, 0, 0, 1);
    tbl[9]  = mk(0, 5'd0,  0, 0,  7, 1, 0, 0, 1);
    tbl[10] = mk(0, 5'd0,  0, 0,  7, 1, 0, 0, 1);
    tbl[11] = mk(1, 5'd7,  0, 0, 14, 2, 0, 0, 1);
    tbl[12] = mk(0, 5'd0,  0, 0, 14, 2, 0, 0, 1);
    tbl[13] = mk(0, 5'd0,  0, 0, 14, 2, 0, 0, 1);
    tbl[14] = mk(1, 5'd7,  0, 0, 21, 3, 0, 0, 1);
    tbl[15] = mk(1, 5'd31, 0, 0, 52, 4, 1, 0, 0);
    tbl[16] = mk(1, 5'd3,  1, 1,  0, 0, 0, 0, 1);
    tbl[17] = mk(1, 5'd9,  0, 0,  9, 1, 0, 0, 1);
    tbl[18] = mk(1, 5'd9,  0, 1,  0, 0, 0, 0, 1);
    tbl[19] = mk(1, 5'd1,  0, 0,  1, 1, 0, 0, 1);

    #2 chk("ready_in_reset", 32'(a.in_ready), 0);
    check_a("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    #1 check_a("after_reset", 0, 0, 0, 0, 1);

    for (int i = 0; i < 20; i++) begin
      step_a(tbl[i].v, tbl[i].beat, tbl[i].ordy, tbl[i].clr);
      check_a($sformatf("vec%0d", i), tbl[i].acc, tbl[i].cnt, tbl[i].av, tbl[i].ovf, tbl[i].rdy);
    end

    @(negedge clk) clear = 1'b1;
    #1 chk("ready_during_clear", 32'(a.in_ready), 0);
    clear = 1'b0;
    step_a(1, 5'd0, 1, 1);

    step_a(1, 5'd6, 0, 0);
    step_a(1, 5'd6, 0, 0);
    check_a("pre_reset", 12, 2, 0, 0, 1);
    #2 reset = 1'b1;
    #1 check_a("mid_reset", 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    step_a(1, 5'd3, 0, 0);
    check_a("post_reset_beat", 3, 1, 0, 0, 1);

`ifdef SUM_ACC_SAT_EN
    exp9 = 255; exp10 = 255;
`else
    exp9 = 23;  exp10 = 54;
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) b.in_valid = 1'b1;
      @(posedge clk);
      #1 b.in_valid = 1'b0;
      #1;
      if (i == 7) begin
        chk("b8.acc", 32'(b.acc_out), 248);
        chk("b8.ovf", 32'(b.overflow), 0);
      end
      if (i == 8) begin
        chk("b9.acc", 32'(b.acc_out), exp9);
        chk("b9.ovf", 32'(b.overflow), 1);
      end
    end
    chk("b10.acc", 32'(b.acc_out), exp10);
    chk("b10.ovf", 32'(b.overflow), 1);
    chk("b10.cnt", 32'(b.sample_cnt), 10);
    chk("b10.valid", 32'(b.acc_valid), 1);
    chk("b10.ready", 32'(b.in_ready), 0);
    @(negedge clk) b.out_ready = 1'b1;
    @(posedge clk);
    #1 b.out_ready = 1'b0;
    #1;
    chk("b_flush.ovf", 32'(b.overflow), 0);
    chk("b_flush.acc", 32'(b.acc_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
